// File: rtl/pulse_monitor.sv
// Receive-side checker for a periodic single-cycle pulse train: measures pulse-to-pulse
// intervals against N +/- TOL, tracks lock, and counts pulses and errors.
module pulse_monitor #(
  parameter int N        = 10,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_in,
  output logic [W-1:0] interval,
  output logic [W-1:0] pulse_count,
  output logic [W-1:0] err_count,
  output logic         locked,
  output logic         err,
  output logic         timeout
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  localparam logic [W-1:0] LO      = W'(N - TOL);
  localparam logic [W-1:0] HI      = W'(N + TOL);
  localparam logic [W-1:0] MAX     = '1;
  localparam logic [3:0]   RUN_TOP = 4'(LOCK_CNT - 1);

  state_t         state;
  logic [W-1:0]   cnt;
  logic [3:0]     good_run;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + W'(1);
  endfunction

  function automatic logic in_range(input logic [W-1:0] v);
    return (v >= LO) && (v <= HI);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      good_run    <= '0;
      interval    <= '0;
      pulse_count <= '0;
      err_count   <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      err     <= 1'b0;
      timeout <= 1'b0;
      cnt     <= pulse_in ? W'(1) : sat_inc(cnt);
      if (pulse_in)
        pulse_count <= pulse_count + W'(1);

      case (state)
        IDLE: begin
          // First pulse only starts the measurement; nothing to compare against yet.
          if (pulse_in)
            state <= ACQUIRE;
        end
        default: begin
          if (pulse_in) begin
            interval <= cnt;
            if (in_range(cnt)) begin
              if (state == ACQUIRE) begin
                if (good_run == RUN_TOP) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  good_run <= '0;
                end else begin
                  good_run <= good_run + 4'd1;
                end
              end
            end else begin
              err       <= 1'b1;
              err_count <= sat_inc(err_count);
              good_run  <= '0;
              state     <= ACQUIRE;
              locked    <= 1'b0;
            end
          end else if (cnt == HI) begin
            // Pulse overdue: drop back so the next pulse is treated as a fresh first pulse.
            err       <= 1'b1;
            timeout   <= 1'b1;
            err_count <= sat_inc(err_count);
            good_run  <= '0;
            state     <= IDLE;
            locked    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
